gate_sweep_sched: RTL and testbench
===================================

GATE_SWEEP_SCHED -- requirements
Module: gate_sweep_sched

Interface
REQ-001 SHALL have parameter DELAY_W, default 32, meaning width of gate delay value and sweep arithmetic.
REQ-002 SHALL have port clk  input  1  sole clock (timing-core clock, 100 MHz domain).
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  one-cycle request to terminate the sweep.
REQ-006 SHALL have port frame_strobe  input  1  one-cycle pulse per CMOS frame boundary.
REQ-007 SHALL have port base_delay  input  DELAY_W  first gate delay of the sweep.
REQ-008 SHALL have port delta_t  input  8  unsigned delay increment per step.
REQ-009 SHALL have port steps_n  input  16  number of delay steps in the sweep.
REQ-010 SHALL have port frames_per_step  input  8  frames dwelt at each step; 0 is treated as 1.
REQ-011 SHALL have port gate_delay_o  output  DELAY_W  delay value presented to the parameter loader.
REQ-012 SHALL have port load_param  output  1  one-cycle pulse commanding the parameter loader to capture.
REQ-013 SHALL have port step_idx  output  16  index of the current step.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-016 SHALL have port sat  output  1  sticky flag: the delay addition saturated during this sweep.

Function
REQ-017 SHALL implement states IDLE, ARM, LOAD, DWELL, DONE; all outputs registered.
REQ-018 In IDLE, start with steps_n!=0 SHALL latch all four sweep inputs, set gate_delay_o=base_delay, step_idx=0, sat=0, and enter ARM next cycle.
REQ-019 In IDLE, start with steps_n==0 SHALL produce a done pulse next cycle and SHALL NOT pulse load_param.
REQ-020 SHALL ignore start when busy=1; latched inputs SHALL NOT change mid-sweep.
REQ-021 In ARM, frame_strobe at cycle t SHALL enter LOAD, with load_param=1 at cycle t+1 only.
REQ-022 LOAD SHALL last one cycle, then enter DWELL with frame counter cleared.
REQ-023 In DWELL, each frame_strobe SHALL increment the frame counter; a strobe while count==frames_per_step-1 ends the step.
REQ-024 Step end at cycle t with step_idx<steps_n-1 SHALL set step_idx+1 and gate_delay_o+delta_t at t+1, with load_param at t+2; gate_delay_o stable one cycle before load_param.
REQ-025 Step end with step_idx==steps_n-1 SHALL enter DONE; done=1 for one cycle, then IDLE; gate_delay_o and step_idx SHALL hold.
REQ-026 Delay addition SHALL saturate at all-ones of DELAY_W and set sat; sat clears only on the next accepted start or on reset.
REQ-027 abort SHALL return to IDLE next cycle from any state, with no done pulse and no load_param; gate_delay_o holds.
REQ-028 abort and start in the same cycle: abort SHALL win.
REQ-029 frame_strobe coincident with abort SHALL be ignored.
REQ-030 frame_strobe during the LOAD or DONE cycle SHALL be ignored; the frame is not counted.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, gate_delay_o=0, step_idx=0, load_param=0, busy=0, done=0, sat=0, frame counter=0.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep; release SHALL NOT resume it.

Configuration
REQ-033 Macro SWEEP_PINGPONG_EN: when defined, after the last upward step the sweep SHALL reverse, subtracting delta_t and decrementing step_idx per step, until step_idx==0 has dwelt; then DONE. Total steps = 2*steps_n-1. Subtraction saturates at 0 and sets sat.
REQ-034 Without SWEEP_PINGPONG_EN, only the upward sweep of REQ-025 SHALL exist, and no down-count logic SHALL be built.

Verification
REQ-035 base=1000, delta=10, steps_n=3, fps=2, strobes every 20 cycles -> load_param 3x; gate_delay_o 1000/1010/1020; done one cycle after the 6th dwell strobe.
REQ-036 fps=0, steps_n=2 -> each step lasts exactly one frame; 2 load_param pulses; done after the 2nd dwell strobe.
REQ-037 steps_n=0 with start -> done at the next cycle; busy stays 0; no load_param.
REQ-038 base=32'hFFFFFFF0, delta=255, steps_n=2 -> second gate_delay_o=32'hFFFFFFFF and sat=1.
REQ-039 abort and start in the same cycle, and abort mid-DWELL -> IDLE next cycle, no done, gate_delay_o unchanged; rst mid-DWELL -> all outputs 0 immediately.
REQ-040 With SWEEP_PINGPONG_EN: base=0, delta=5, steps_n=3, fps=1 -> delays 0,5,10,5,0; 5 load_param pulses; then done.

Source files
------------

// File: rtl/gate_sweep_sched.sv
// gate_sweep_sched: steps a gate delay across a sweep, one parameter-loader pulse per step, dwelling N frames per step.
// Latency: load_param 1 cycle after the arming strobe, 2 cycles after a step-ending strobe; done 1 cycle after the last strobe.
// No backpressure: strobes in LOAD, the pre-load cycle or DONE are dropped; define SWEEP_PINGPONG_EN for a return sweep.
module gate_sweep_sched #(
  parameter int DELAY_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               frame_strobe,
  input  logic [DELAY_W-1:0] base_delay,
  input  logic [7:0]         delta_t,
  input  logic [15:0]        steps_n,
  input  logic [7:0]         frames_per_step,
  output logic [DELAY_W-1:0] gate_delay_o,
  output logic               load_param,
  output logic [15:0]        step_idx,
  output logic               busy,
  output logic               done,
  output logic               sat
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DWELL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         r_state;
  logic [DELAY_W-1:0] r_delay;
  logic [15:0]        r_step;
  logic [15:0]        r_steps_m1;
  logic [7:0]         r_delta;
  logic [7:0]         r_fps_m1;
  logic [7:0]         r_cnt;
  logic               r_load;
  logic               r_busy;
  logic               r_done;
  logic               r_sat;
  // Step has advanced; the loader pulse follows one cycle later so the new delay is settled first.
  logic               r_pend;

  logic [DELAY_W:0]   w_sum;
  logic               w_ovf;
  logic [DELAY_W-1:0] w_up;
  logic               w_last;
`ifdef SWEEP_PINGPONG_EN
  logic               r_down;
  logic [DELAY_W:0]   w_diff;
  logic               w_unf;
  logic [DELAY_W-1:0] w_dn;
`endif

  // Saturating next-delay arithmetic and end-of-sweep detection
  always_comb begin
    w_sum = {1'b0, r_delay} + {{(DELAY_W-7){1'b0}}, r_delta};
    w_ovf = w_sum[DELAY_W];
    w_up  = w_ovf ? {DELAY_W{1'b1}} : w_sum[DELAY_W-1:0];
`ifdef SWEEP_PINGPONG_EN
    w_diff = {1'b0, r_delay} - {{(DELAY_W-7){1'b0}}, r_delta};
    w_unf  = w_diff[DELAY_W];
    w_dn   = w_unf ? {DELAY_W{1'b0}} : w_diff[DELAY_W-1:0];
    // A single-step sweep has no return leg; otherwise finish once index 0 has dwelt on the way down.
    w_last = r_down ? (r_step == 16'd0) : (r_steps_m1 == 16'd0);
`else
    w_last = (r_step == r_steps_m1);
`endif
  end

  // Sweep sequencer: arming, loading, frame dwell and step advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_delay    <= '0;
      r_step     <= '0;
      r_steps_m1 <= '0;
      r_delta    <= '0;
      r_fps_m1   <= '0;
      r_cnt      <= '0;
      r_load     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
      r_pend     <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      r_down     <= 1'b0;
`endif
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_pend  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (steps_n == 16'd0) begin
                r_done <= 1'b1;
              end else begin
                r_delay    <= base_delay;
                r_delta    <= delta_t;
                r_steps_m1 <= steps_n - 16'd1;
                r_fps_m1   <= (frames_per_step == 8'd0) ? 8'd0 : frames_per_step - 8'd1;
                r_step     <= '0;
                r_sat      <= 1'b0;
                r_cnt      <= '0;
                r_state    <= S_ARM;
                r_busy     <= 1'b1;
`ifdef SWEEP_PINGPONG_EN
                r_down     <= 1'b0;
`endif
              end
            end
          end
          S_ARM: begin
            if (frame_strobe) begin
              r_state <= S_LOAD;
              r_load  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state <= S_DWELL;
            r_cnt   <= '0;
          end
          S_DWELL: begin
            if (r_pend) begin
              r_pend  <= 1'b0;
              r_state <= S_LOAD;
              r_load  <= 1'b1;
            end else if (frame_strobe) begin
              if (r_cnt == r_fps_m1) begin
                r_cnt <= '0;
                if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_pend <= 1'b1;
`ifdef SWEEP_PINGPONG_EN
                  if (r_down || (r_step == r_steps_m1)) begin
                    r_down  <= 1'b1;
                    r_step  <= r_step - 16'd1;
                    r_delay <= w_dn;
                    r_sat   <= r_sat | w_unf;
                  end else begin
                    r_step  <= r_step + 16'd1;
                    r_delay <= w_up;
                    r_sat   <= r_sat | w_ovf;
                  end
`else
                  r_step  <= r_step + 16'd1;
                  r_delay <= w_up;
                  r_sat   <= r_sat | w_ovf;
`endif
                end
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gate_delay_o = r_delay;
  assign load_param   = r_load;
  assign step_idx     = r_step;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sat          = r_sat;

endmodule

// File: tb/tb_gate_sweep_sched.sv
// tb_gate_sweep_sched: randomized sweeps checked against an arithmetic model of the delay sequence and strobe timing.
// Directed cases cover saturation, zero steps, frames_per_step=0, abort and mid-sweep reset.
// Strobes are spaced at least 4 cycles apart so none fall in the dropped LOAD/pre-load/DONE cycles.
module tb_gate_sweep_sched;
  localparam int     DW   = 32;
  localparam longint MAXD = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst, start, abort, frame_strobe;
  logic [DW-1:0] base_delay;
  logic [7:0]    delta_t;
  logic [15:0]   steps_n;
  logic [7:0]    frames_per_step;
  logic [DW-1:0] gate_delay_o;
  logic          load_param;
  logic [15:0]   step_idx;
  logic          busy, done, sat;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int            ld_cyc[$];
  longint        ld_dly[$];
  int            ld_idx[$];
  int            done_cyc[$];
  int            st_edge[$];
  logic [DW-1:0] prev_dly = '0;

  gate_sweep_sched #(.DELAY_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .frame_strobe    (frame_strobe),
    .base_delay      (base_delay),
    .delta_t         (delta_t),
    .steps_n         (steps_n),
    .frames_per_step (frames_per_step),
    .gate_delay_o    (gate_delay_o),
    .load_param      (load_param),
    .step_idx        (step_idx),
    .busy            (busy),
    .done            (done),
    .sat             (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Log loader pulses and done pulses; the delay must already be stable the cycle before a load.
  always @(negedge clk) begin
    if (load_param === 1'b1) begin
      ld_cyc.push_back(cyc);
      ld_dly.push_back(longint'(gate_delay_o));
      ld_idx.push_back(int'(step_idx));
      check_eq("dly_stable_before_load", gate_delay_o, prev_dly);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    prev_dly = gate_delay_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    ld_cyc.delete();
    ld_dly.delete();
    ld_idx.delete();
    done_cyc.delete();
    st_edge.delete();
  endtask

  task automatic pulse_strobe();
    frame_strobe = 1'b1;
    st_edge.push_back(cyc + 1);
    tick(1);
    frame_strobe = 1'b0;
  endtask

  task automatic run_sweep(input logic [31:0] b, input logic [7:0] d, input logic [15:0] n, input logic [7:0] f);
    longint cur;
    bit     s;
    longint exp_d[$];
    int     exp_i[$];
    int     fe, nst, guard, idx;
    clear_logs();
    base_delay = b; delta_t = d; steps_n = n; frames_per_step = f;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    base_delay = $urandom; delta_t = 8'($urandom); steps_n = 16'($urandom); frames_per_step = 8'($urandom);
    if (n == 16'd0) begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
      tick(1);
      check_eq("zero_done_width", done, 0);
      check_eq("zero_busy_after", busy, 0);
      tick(5);
      check_eq("zero_loads", ld_cyc.size(), 0);
      check_eq("zero_done_count", done_cyc.size(), 1);
    end else begin
      check_eq("start_busy", busy, 1);
      check_eq("start_dly", gate_delay_o, b);
      check_eq("start_idx", step_idx, 0);
      check_eq("start_sat", sat, 0);
      // Expected step sequence from plain saturating arithmetic
      cur = longint'(b);
      s   = 1'b0;
      for (int k = 0; k < int'(n); k++) begin
        if (k > 0) begin
          cur = cur + longint'(d);
          if (cur > MAXD) begin cur = MAXD; s = 1'b1; end
        end
        exp_d.push_back(cur);
        exp_i.push_back(k);
      end
`ifdef SWEEP_PINGPONG_EN
      for (int k = int'(n) - 2; k >= 0; k--) begin
        cur = cur - longint'(d);
        if (cur < 0) begin cur = 0; s = 1'b1; end
        exp_d.push_back(cur);
        exp_i.push_back(k);
      end
`endif
      fe    = (f == 8'd0) ? 1 : int'(f);
      nst   = exp_d.size();
      guard = 0;
      while (done_cyc.size() == 0 && guard < 200) begin
        tick($urandom_range(4, 9));
        if (done_cyc.size() == 0) begin
          pulse_strobe();
          guard++;
          if (guard == 2) begin
            start = 1'b1;
            tick(1);
            start = 1'b0;
          end
        end
      end
      tick(2);
      if (guard >= 200) check_eq("sweep_timeout", done_cyc.size(), 1);
      check_eq("strobes_used", st_edge.size(), nst * fe + 1);
      check_eq("load_count", ld_cyc.size(), nst);
      for (int k = 0; k < nst && k < ld_cyc.size(); k++) begin
        check_eq("load_dly", ld_dly[k], exp_d[k]);
        check_eq("load_idx", ld_idx[k], exp_i[k]);
        idx = k * fe;
        if (idx < st_edge.size())
          check_eq("load_cycle", ld_cyc[k], (k == 0) ? st_edge[0] : st_edge[idx] + 1);
      end
      check_eq("done_count", done_cyc.size(), 1);
      if (done_cyc.size() > 0 && st_edge.size() > nst * fe)
        check_eq("done_cycle", done_cyc[0], st_edge[nst * fe]);
      check_eq("end_busy", busy, 0);
      check_eq("end_sat", sat, s);
      check_eq("hold_dly", gate_delay_o, exp_d[nst-1]);
      check_eq("hold_idx", step_idx, exp_i[nst-1]);
    end
    tick(3);
  endtask

  task automatic abort_tests();
    clear_logs();
    base_delay = 32'd123; delta_t = 8'd9; steps_n = 16'd3; frames_per_step = 8'd2;
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", busy, 0);
    check_eq("abort_start_done", done, 0);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4); pulse_strobe();
    tick(4); pulse_strobe();
    tick(4); pulse_strobe();
    tick(4); pulse_strobe();
    tick(4);
    check_eq("pre_abort_dly", gate_delay_o, 132);
    abort = 1'b1; frame_strobe = 1'b1;
    tick(1);
    abort = 1'b0; frame_strobe = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_load", load_param, 0);
    check_eq("abort_dly_hold", gate_delay_o, 132);
    check_eq("abort_idx_hold", step_idx, 1);
    tick(2);
    check_eq("abort_load_count", ld_cyc.size(), 2);
    pulse_strobe(); tick(4); pulse_strobe(); tick(4);
    check_eq("abort_no_done", done_cyc.size(), 0);
    check_eq("abort_no_more_loads", ld_cyc.size(), 2);
  endtask

  task automatic reset_test();
    clear_logs();
    base_delay = 32'h5555; delta_t = 8'd1; steps_n = 16'd4; frames_per_step = 8'd3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4); pulse_strobe();
    tick(4); pulse_strobe();
    tick(2);
    rst = 1'b1;
    #1;
    check_eq("rst_dly", gate_delay_o, 0);
    check_eq("rst_idx", step_idx, 0);
    check_eq("rst_load", load_param, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sat", sat, 0);
    tick(2);
    rst = 1'b0;
    clear_logs();
    tick(4); pulse_strobe(); tick(4); pulse_strobe(); tick(4);
    check_eq("rst_no_resume_busy", busy, 0);
    check_eq("rst_no_resume_loads", ld_cyc.size(), 0);
    check_eq("rst_no_resume_done", done_cyc.size(), 0);
  endtask

  initial begin
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; abort = 1'b0; frame_strobe = 1'b0;
    base_delay = '0; delta_t = '0; steps_n = '0; frames_per_step = '0;
    tick(3);
    check_eq("reset_dly", gate_delay_o, 0);
    check_eq("reset_idx", step_idx, 0);
    check_eq("reset_load", load_param, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_sat", sat, 0);
    rst = 1'b0;
    tick(2);

    run_sweep(32'd1000, 8'd10, 16'd3, 8'd2);
    run_sweep(32'd500, 8'd7, 16'd2, 8'd0);
    run_sweep(32'd77, 8'd3, 16'd0, 8'd2);
    run_sweep(32'hFFFF_FFF0, 8'd255, 16'd2, 8'd1);
`ifdef SWEEP_PINGPONG_EN
    run_sweep(32'd0, 8'd5, 16'd3, 8'd1);
`endif
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 2))
        0:       rb = 32'hFFFF_FE00 | 32'($urandom_range(0, 511));
        1:       rb = 32'($urandom_range(0, 300));
        default: rb = $urandom;
      endcase
      run_sweep(rb, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 5)), 8'($urandom_range(0, 3)));
    end

    abort_tests();
    reset_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
